// File: rtl/cga_intr_lvl_ctrl.sv
// Interrupt level controller for the CGA INTR section: NLEV levels of edge-detected
// pending requests, priority resolution against the program level, and an ACK/IDENT handshake.
module cga_intr_lvl_ctrl #(
  parameter int NLEV = 16,
  parameter int VECW = 3,
  parameter int LW   = 4
) (
  input  logic                 mclk_i,
  input  logic                 rst_i,
  input  logic [NLEV-1:0]      det_i,
  input  logic                 pie_we_i,
  input  logic [NLEV-1:0]      pie_d_i,
  input  logic [LW-1:0]        pil_i,
  input  logic                 passall_i,
  input  logic                 ack_i,
  input  logic [NLEV*VECW-1:0] srcvec_i,
  output logic                 irq_o,
  output logic [LW-1:0]        irq_lvl_o,
  output logic                 ack_valid_o,
  output logic [LW+VECW-1:0]   vec_o,
  output logic [NLEV-1:0]      pend_o,
  output logic [NLEV-1:0]      enabn_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP    = 2'd1,
    WAITLOW = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NLEV-1:0]     det_q;
  logic [NLEV-1:0]     pend_q, pend_d;
  logic [NLEV-1:0]     pie_q, pie_d;
  logic                irq_q, irq_d;
  logic [LW-1:0]       irq_lvl_q, irq_lvl_d;
  logic [LW+VECW-1:0]  vec_q, vec_d;

  logic [NLEV-1:0]     rise;
  logic [NLEV-1:0]     clr;
  logic [NLEV-1:0]     elig;
  logic                eligAny;
  logic [LW-1:0]       highLvl;
  logic                req;
  logic                capture;
  logic [VECW-1:0]     srcSel;

  assign rise = det_i & ~det_q;

  always_comb begin
    elig    = pend_q & (pie_q | {NLEV{passall_i}});
    eligAny = |elig;
    highLvl = '0;
    for (int i = 0; i < NLEV; i++) begin
      if (elig[i]) begin
        highLvl = LW'(i);
      end
    end
    req = eligAny && (highLvl > pil_i);
  end

  // Capture serves the registered request, so a level arriving in the ACK cycle waits for the next ACK.
  always_comb begin
    srcSel = '0;
    for (int i = 0; i < NLEV; i++) begin
      if (irq_lvl_q == LW'(i)) begin
        srcSel = srcvec_i[i*VECW +: VECW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ack_i) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = WAITLOW;
      end
      WAITLOW: begin
        if (!ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = WAITLOW;
      end
    endcase
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NLEV; i++) begin
      if (capture && irq_q && (irq_lvl_q == LW'(i))) begin
        clr[i] = 1'b1;
      end
    end
  end

  // A new edge on a level wins over its own clear in the same cycle.
  always_comb begin
    pend_d    = (pend_q & ~clr) | rise;
    pie_d     = pie_we_i ? pie_d_i : pie_q;
    irq_d     = req;
    irq_lvl_d = req ? highLvl : '0;
    vec_d     = vec_q;
    if (capture) begin
      vec_d = irq_q ? {irq_lvl_q, srcSel} : '0;
    end
  end

  always_ff @(posedge mclk_i) begin
    if (rst_i) begin
      state_q   <= WAITLOW;
      det_q     <= '0;
      pend_q    <= '0;
      pie_q     <= '0;
      irq_q     <= 1'b0;
      irq_lvl_q <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_i;
      pend_q    <= pend_d;
      pie_q     <= pie_d;
      irq_q     <= irq_d;
      irq_lvl_q <= irq_lvl_d;
      vec_q     <= vec_d;
    end
  end

  assign irq_o       = irq_q;
  assign irq_lvl_o   = irq_lvl_q;
  assign ack_valid_o = (state_q == RESP);
  assign vec_o       = vec_q;
  assign pend_o      = pend_q;
  assign enabn_o     = ~pie_q;

endmodule

// File: tb/tb_cga_intr_lvl_ctrl.sv
// Self-checking bench for cga_intr_lvl_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_cga_intr_lvl_ctrl;

  localparam int NLEV = 16;
  localparam int VECW = 3;
  localparam int LW   = 4;

  logic                 mclk;
  logic                 rst;
  logic [NLEV-1:0]      det;
  logic                 pieWe;
  logic [NLEV-1:0]      pieD;
  logic [LW-1:0]        pil;
  logic                 passall;
  logic                 ack;
  logic [NLEV*VECW-1:0] srcvec;
  logic                 irq;
  logic [LW-1:0]        irqLvl;
  logic                 ackValid;
  logic [LW+VECW-1:0]   vec;
  logic [NLEV-1:0]      pend;
  logic [NLEV-1:0]      enabn;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [NLEV-1:0]    mDet = '0;
  logic [NLEV-1:0]    mPend = '0;
  logic [NLEV-1:0]    mPie = '0;
  logic               mIrq = 1'b0;
  logic [LW-1:0]      mLvl = '0;
  logic [LW+VECW-1:0] mVec = '0;
  bit                 mArmed = 1'b0;
  bit                 mStrobe = 1'b0;

  cga_intr_lvl_ctrl #(.NLEV(NLEV), .VECW(VECW), .LW(LW)) dut (
    .mclk_i     (mclk),
    .rst_i      (rst),
    .det_i      (det),
    .pie_we_i   (pieWe),
    .pie_d_i    (pieD),
    .pil_i      (pil),
    .passall_i  (passall),
    .ack_i      (ack),
    .srcvec_i   (srcvec),
    .irq_o      (irq),
    .irq_lvl_o  (irqLvl),
    .ack_valid_o(ackValid),
    .vec_o      (vec),
    .pend_o     (pend),
    .enabn_o    (enabn)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Advance one clock edge; the model evaluates the rules on the inputs present at that edge.
  task automatic step();
    logic [NLEV-1:0]    nDet, nPend, nPie, rise, clr;
    logic               nIrq;
    logic [LW-1:0]      nLvl;
    logic [LW+VECW-1:0] nVec;
    bit                 nArmed, nStrobe, found;
    int                 h;
    if (rst) begin
      nDet = '0; nPend = '0; nPie = '0; nIrq = 1'b0; nLvl = '0; nVec = '0;
      nArmed = 1'b0; nStrobe = 1'b0;
    end else begin
      nDet = det;
      rise = det & ~mDet;
      clr = '0;
      nVec = mVec;
      nArmed = mArmed;
      nStrobe = 1'b0;
      if (mStrobe) begin
        nArmed = 1'b0;
      end else if (mArmed) begin
        if (ack) begin
          nStrobe = 1'b1;
          nArmed = 1'b0;
          if (mIrq) begin
            clr[mLvl] = 1'b1;
            nVec = {mLvl, srcvec[int'(mLvl)*VECW +: VECW]};
          end else begin
            nVec = '0;
          end
        end
      end else begin
        nArmed = !ack;
      end
      nPend = (mPend & ~clr) | rise;
      nPie = pieWe ? pieD : mPie;
      found = 1'b0;
      h = 0;
      for (int i = 0; i < NLEV; i++) begin
        if (mPend[i] && (mPie[i] || passall)) begin
          found = 1'b1;
          h = i;
        end
      end
      nIrq = found && (h > int'(pil));
      nLvl = nIrq ? LW'(h) : '0;
    end
    @(posedge mclk);
    #1;
    mDet = nDet; mPend = nPend; mPie = nPie; mIrq = nIrq; mLvl = nLvl; mVec = nVec;
    mArmed = nArmed; mStrobe = nStrobe;
  endtask

  task automatic do_reset();
    rst = 1'b1; det = '0; pieWe = 1'b0; pieD = '0; pil = '0; passall = 1'b0; ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_pie(input logic [NLEV-1:0] mask);
    pieWe = 1'b1; pieD = mask;
    step();
    pieWe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; det = 16'h1000; pieWe = 1'b0; pieD = '0; pil = '0; passall = 1'b0; ack = 1'b1;
    srcvec = '0;
    step();
    step();
    checks++;
    if ({irq, irqLvl, ackValid, vec, pend} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs irq=%b lvl=%0d av=%b vec=%h pend=%h expected all zero",
               irq, irqLvl, ackValid, vec, pend);
    end
    checks++;
    if (enabn !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL reset_enabn got=%h expected=ffff", enabn);
    end
    rst = 1'b0; ack = 1'b0;
    step();
    checks++;
    if (pend !== 16'h1000) begin
      failures++;
      $display("[TB] FAIL reset_det_held pend got=%h expected=1000", pend);
    end
    step();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_masked_irq got=%b expected=0", irq);
    end
    det = '0;
  endtask

  task automatic test_basic_serve();
    do_reset();
    srcvec = {$urandom, $urandom};
    srcvec[11*VECW +: VECW] = 3'b101;
    load_pie(16'h3C00);
    det[11] = 1'b1;
    step();
    checks++;
    if (pend !== 16'h0800 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_pend pend=%h irq=%b expected pend=0800 irq=0", pend, irq);
    end
    det = '0;
    step();
    checks++;
    if (irq !== 1'b1 || irqLvl !== 4'd11) begin
      failures++;
      $display("[TB] FAIL basic_irq irq=%b lvl=%0d expected irq=1 lvl=11", irq, irqLvl);
    end
    ack = 1'b1;
    step();
    checks++;
    if (ackValid !== 1'b1 || vec !== 7'h5D || pend !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL basic_capture av=%b vec=%h pend=%h expected av=1 vec=5d pend=0000",
               ackValid, vec, pend);
    end
    step();
    checks++;
    if (ackValid !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_after av=%b irq=%b expected av=0 irq=0", ackValid, irq);
    end
    step();
    checks++;
    if (ackValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_ack_held av=%b expected=0", ackValid);
    end
    ack = 1'b0;
    step();
    checks++;
    if (vec !== 7'h5D) begin
      failures++;
      $display("[TB] FAIL basic_vec_hold vec=%h expected=5d", vec);
    end
  endtask

  task automatic test_priority_pil();
    logic [LW+VECW-1:0] expVec;
    do_reset();
    srcvec = {$urandom, $urandom};
    expVec = {4'd13, srcvec[13*VECW +: VECW]};
    load_pie(16'hFFFF);
    pil = 4'd13;
    det = 16'h2400;
    step();
    det = '0;
    step();
    checks++;
    if (irq !== 1'b0 || pend !== 16'h2400) begin
      failures++;
      $display("[TB] FAIL pil_block irq=%b pend=%h expected irq=0 pend=2400", irq, pend);
    end
    pil = 4'd12;
    step();
    checks++;
    if (irq !== 1'b1 || irqLvl !== 4'd13) begin
      failures++;
      $display("[TB] FAIL pil_pass irq=%b lvl=%0d expected irq=1 lvl=13", irq, irqLvl);
    end
    ack = 1'b1;
    step();
    checks++;
    if (ackValid !== 1'b1 || vec !== expVec || pend !== 16'h0400) begin
      failures++;
      $display("[TB] FAIL pil_serve av=%b vec=%h pend=%h expected av=1 vec=%h pend=0400",
               ackValid, vec, pend, expVec);
    end
    ack = 1'b0; pil = 4'd0;
    step();
    checks++;
    if (irq !== 1'b1 || irqLvl !== 4'd10) begin
      failures++;
      $display("[TB] FAIL pil_next irq=%b lvl=%0d expected irq=1 lvl=10", irq, irqLvl);
    end
    step();
  endtask

  task automatic test_passall();
    do_reset();
    det = 16'h4000;
    step();
    det = '0;
    step();
    checks++;
    if (irq !== 1'b0 || pend !== 16'h4000) begin
      failures++;
      $display("[TB] FAIL passall_masked irq=%b pend=%h expected irq=0 pend=4000", irq, pend);
    end
    passall = 1'b1;
    step();
    checks++;
    if (irq !== 1'b1 || irqLvl !== 4'd14) begin
      failures++;
      $display("[TB] FAIL passall_on irq=%b lvl=%0d expected irq=1 lvl=14", irq, irqLvl);
    end
    passall = 1'b0;
    step();
    checks++;
    if (irq !== 1'b0 || pend !== 16'h4000 || enabn !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL passall_off irq=%b pend=%h enabn=%h expected irq=0 pend=4000 enabn=ffff",
               irq, pend, enabn);
    end
  endtask

  task automatic test_spurious_collision();
    do_reset();
    step();
    ack = 1'b1;
    step();
    checks++;
    if (ackValid !== 1'b1 || vec !== '0) begin
      failures++;
      $display("[TB] FAIL spurious av=%b vec=%h expected av=1 vec=00", ackValid, vec);
    end
    ack = 1'b0;
    step();
    step();
    load_pie(16'h0800);
    det[11] = 1'b1;
    step();
    det = '0;
    step();
    ack = 1'b1; det[11] = 1'b1;
    step();
    checks++;
    if (ackValid !== 1'b1 || vec[6:3] !== 4'd11 || pend !== 16'h0800) begin
      failures++;
      $display("[TB] FAIL collision av=%b vec=%h pend=%h expected av=1 lvl=11 pend=0800",
               ackValid, vec, pend);
    end
    ack = 1'b0; det = '0;
    step();
    checks++;
    if (irq !== 1'b1 || irqLvl !== 4'd11) begin
      failures++;
      $display("[TB] FAIL collision_irq irq=%b lvl=%0d expected irq=1 lvl=11", irq, irqLvl);
    end
    step();
  endtask

  task automatic test_reset_mid_handshake();
    do_reset();
    load_pie(16'hFFFF);
    det = 16'h0020;
    step();
    det = '0;
    step();
    ack = 1'b1;
    step();
    checks++;
    if (ackValid !== 1'b1 || vec[6:3] !== 4'd5) begin
      failures++;
      $display("[TB] FAIL mid_capture av=%b vec=%h expected av=1 lvl=5", ackValid, vec);
    end
    rst = 1'b1;
    step();
    checks++;
    if (ackValid !== 1'b0 || pend !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mid_reset av=%b pend=%h expected av=0 pend=0000", ackValid, pend);
    end
    rst = 1'b0;
    load_pie(16'hFFFF);
    det = 16'h0040;
    step();
    det = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (ackValid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mid_ack_ignored cycle=%0d av=%b expected=0", c, ackValid);
      end
    end
    checks++;
    if (irq !== 1'b1 || irqLvl !== 4'd6) begin
      failures++;
      $display("[TB] FAIL mid_irq irq=%b lvl=%0d expected irq=1 lvl=6", irq, irqLvl);
    end
    ack = 1'b0;
    step();
    ack = 1'b1;
    step();
    checks++;
    if (ackValid !== 1'b1 || vec[6:3] !== 4'd6) begin
      failures++;
      $display("[TB] FAIL mid_recapture av=%b vec=%h expected av=1 lvl=6", ackValid, vec);
    end
    ack = 1'b0;
    step();
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      det = $urandom_range(0, 3) == 0 ? NLEV'($urandom) & NLEV'($urandom) : '0;
      pieWe = ($urandom_range(0, 15) == 0);
      pieD = NLEV'($urandom);
      if ($urandom_range(0, 7) == 0) pil = LW'($urandom);
      if ($urandom_range(0, 15) == 0) passall = ~passall;
      if ($urandom_range(0, 2) == 0) ack = ~ack;
      srcvec = {$urandom, $urandom};
      rst = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if (irq !== mIrq || irqLvl !== mLvl) begin
        failures++;
        $display("[TB] FAIL rand_irq cycle=%0d irq=%b lvl=%0d expected irq=%b lvl=%0d",
                 c, irq, irqLvl, mIrq, mLvl);
      end
      checks++;
      if (ackValid !== mStrobe || vec !== mVec) begin
        failures++;
        $display("[TB] FAIL rand_ack cycle=%0d av=%b vec=%h expected av=%b vec=%h",
                 c, ackValid, vec, mStrobe, mVec);
      end
      checks++;
      if (pend !== mPend || enabn !== ~mPie) begin
        failures++;
        $display("[TB] FAIL rand_state cycle=%0d pend=%h enabn=%h expected pend=%h enabn=%h",
                 c, pend, enabn, mPend, ~mPie);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; det = '0; pieWe = 1'b0; pieD = '0; pil = '0; passall = 1'b0; ack = 1'b0;
    srcvec = '0;
    test_reset();
    test_basic_serve();
    test_priority_pil();
    test_passall();
    test_spurious_collision();
    test_reset_mid_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cga_intr_lvl_ctrl.md
Name: cga_intr_lvl_ctrl

Overview:
- Parametrised interrupt level controller for the CGA INTR section; generalises the single high-level request/enable/pass-all slice to NLEV levels.
- Per level: edge detection, pending latch and enable bit.
- Resolves the highest eligible level against the current program level and raises a registered request.
- Serves a CPU acknowledge handshake that returns a composite vector {level, source vector} and auto-clears the served level.

Parameters:
NLEV, 16, number of interrupt levels (2..16); level index NLEV-1 is highest priority
VECW, 3, width of the per-level source vector
LW, 4, level index width; must satisfy 2**LW >= NLEV

Ports:
MCLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
DET  in  NLEV  per-level request detect, sampled every MCLK
PIE_WE  in  1  load enable mask
PIE_D  in  NLEV  enable mask data
PIL  in  LW  current program level
PASSALL  in  1  pass-all mode: treat every level as enabled
ACK  in  1  CPU interrupt acknowledge (IDENT)
SRCVEC  in  NLEV*VECW  per-level source vector; level i uses bits [i*VECW +: VECW]
IRQ  out  1  registered interrupt request
IRQ_LVL  out  LW  highest eligible pending level (registered)
ACK_VALID  out  1  one-cycle strobe: VEC is valid
VEC  out  LW+VECW  {served level, SRCVEC slice}; all zero = null/spurious
PEND  out  NLEV  pending register
ENABN  out  NLEV  inverted enable mask

Behaviour:
- Reset (RST=1 at an edge):
  - PEND=0, PIE=0 (ENABN all 1), DET history=0, IRQ=0, IRQ_LVL=0, ACK_VALID=0, VEC=0, FSM=WAITLOW.
  - A DET input held high through reset therefore becomes pending on the first edge after RST drops.
- Edge detect: rise[i] = DET[i] & ~det_q[i]. det_q <= DET every cycle.
- Pending update: PEND[i] <= (PEND[i] & ~clr[i]) | rise[i]. Set wins over clear in the same cycle.
- Enable mask:
  - PIE_WE=1 loads PIE <= PIE_D. The new mask is used from the next cycle.
  - An ACK accepted in the same cycle uses the old mask.
- Eligibility:
  - elig = PEND & (PIE | {NLEV{PASSALL}}).
  - Priority encode the highest set index h.
  - req = elig!=0 && h > PIL, compared unsigned. Level 0 can never request.
- IRQ <= req and IRQ_LVL <= (req ? h : 0), both registered.
  - Latency: DET rise at edge n -> PEND set at edge n -> IRQ high at edge n+1.
- FSM (IDLE, RESP, WAITLOW):
  - IDLE, ACK=1: capture. If IRQ=1, VEC <= {IRQ_LVL, SRCVEC[IRQ_LVL]} and clr[IRQ_LVL]=1. If IRQ=0, VEC <= 0 (spurious). Go to RESP.
  - RESP: ACK_VALID=1 for exactly one cycle, then go to WAITLOW.
  - WAITLOW: stay while ACK=1; go to IDLE when ACK=0. ACK held high never produces a second capture.
  - ACK_VALID is 0 in all states except RESP. VEC holds its value until the next capture.
- Capture uses the registered IRQ/IRQ_LVL, not the combinational h. A higher level arriving in the capture cycle is served on the next ACK.
- IRQ is recomputed the cycle after clr. It drops if no other eligible level is above PIL.
- PIL or PASSALL changes take effect on IRQ one cycle later. Pending state is never lost by masking: a masked level stays in PEND.
- Reset mid-handshake: FSM=WAITLOW, so an ACK still high after reset is ignored until it drops. PEND is cleared.
- Widths: all comparisons unsigned on LW bits. Levels >= NLEV do not exist and IRQ_LVL never reaches them.

Test Plan:
- Reset: hold DET[12]=1 through RST -> all outputs 0 and ENABN=all-ones during reset. After release: PEND[12]=1 at the first edge, IRQ stays 0 because PIE=0.
- Basic serve: PIE=0x3C00, PIL=0, pulse DET[11] with SRCVEC[11]=3'b101 -> IRQ=1 and IRQ_LVL=11 one cycle after PEND sets. ACK high 3 cycles -> one ACK_VALID pulse, VEC={4'd11,3'b101}, PEND[11]=0, IRQ=0 next cycle.
- Priority/PIL: pend levels 10 and 13 with PIL=13 -> IRQ=0. PIL=12 -> IRQ_LVL=13. After serving 13 -> IRQ_LVL=10.
- Pass-all and masking: PIE=0, PEND[14]=1 -> IRQ=0. PASSALL=1 -> IRQ=1, IRQ_LVL=14. PASSALL=0 -> IRQ=0, PEND[14] still 1.
- Spurious/collision: ACK with IRQ=0 -> ACK_VALID, VEC=0. DET[11] rises in the same cycle that level 11 is cleared by ACK -> PEND[11] remains 1.
- Reset mid-handshake: RST in RESP with ACK high -> ACK_VALID=0. No capture until ACK drops and rises again.
